bram_window_fetch: RTL and testbench
====================================

BRAM_WINDOW_FETCH -- requirements
Module: bram_window_fetch

Interface
REQ-001 SHALL have parameter IMG_W, default 512, meaning image width in pixels; power of two, 2..512.
REQ-002 SHALL have parameter IMG_H, default 512, meaning image height in pixels; power of two, 2..512; IMG_W*IMG_H <= 2**`ADDR_WIDTH.
REQ-003 SHALL take `ADDR_WIDTH (18) and `BIT_WIDTH (8) from common.vh.
REQ-004 SHALL have port clka, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: begin one full-frame scan.
REQ-007 SHALL have port busy, output, 1 bit: scan in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the last window is accepted.
REQ-009 SHALL have port bram_ena, output, 1 bit: BRAM port enable.
REQ-010 SHALL have port bram_wea, output, 1 bit: BRAM write enable, constant 0.
REQ-011 SHALL have port bram_addra, output, `ADDR_WIDTH bits: BRAM read address.
REQ-012 SHALL have port bram_douta, input, `BIT_WIDTH bits: BRAM read data, valid one cycle after an enabled address.
REQ-013 SHALL have port win_valid, output, 1 bit: window available.
REQ-014 SHALL have port win_ready, input, 1 bit: downstream accepts the window.
REQ-015 SHALL have port win_data, output, 9*`BIT_WIDTH bits: 3x3 window, p0 in [7:0] through p8 in [71:64], row-major, p4 is the centre.
REQ-016 SHALL have port win_addr, output, `ADDR_WIDTH bits: centre pixel address, row*IMG_W+col.

Function
REQ-017 SHALL implement the FSM IDLE -> FETCH -> WAIT -> EMIT -> (FETCH | DONE) -> IDLE.
REQ-018 SHALL in IDLE move to FETCH on start=1 and SHALL ignore start in every other state.
REQ-019 SHALL in FETCH spend exactly 9 cycles, cycle k (0..8) targeting neighbour (row+k/3-1, col+k%3-1).
REQ-020 SHALL for an in-range neighbour drive bram_ena=1 with that address, and capture bram_douta into slot k on the next cycle.
REQ-021 SHALL for an out-of-range neighbour drive bram_ena=0, bram_addra=0, and load slot k with 0 under the same one-cycle alignment.
REQ-022 SHALL spend one WAIT cycle to capture slot 8, then enter EMIT.
REQ-023 SHALL in EMIT hold win_valid=1, with win_data and win_addr stable, until win_valid&win_ready, and SHALL drive bram_ena=0 throughout EMIT.
REQ-024 SHALL after a handshake advance col, wrap col to 0 and increment row at col=IMG_W-1, and go to FETCH, or to DONE after (IMG_H-1, IMG_W-1).
REQ-025 SHALL in DONE pulse done=1 for one cycle and return to IDLE, with busy=0 from then on.
REQ-026 SHALL set the timing: start sampled at edge 0; addresses in cycles 1..9; WAIT in cycle 10; win_valid=1 from cycle 11; each later window valid 11 cycles after the previous handshake.
REQ-027 SHALL assert busy=1 in FETCH, WAIT, EMIT and DONE.
REQ-028 SHALL emit exactly IMG_W*IMG_H windows per start, in raster order.

Reset
REQ-029 SHALL when rst_n=0 at a clock edge enter IDLE and clear row, col, slots, busy, done, win_valid, bram_ena, bram_addra and win_addr to 0.
REQ-030 SHALL on reset mid-scan abandon the frame with no done pulse, and SHALL require a new start after reset.

Configuration
REQ-031 SHALL when macro REPLICATE_BORDER_EN is defined clamp each out-of-range neighbour coordinate to [0, IMG_W-1] / [0, IMG_H-1] and read that pixel from BRAM with bram_ena=1, so no slot is zero-forced.
REQ-032 SHALL when REPLICATE_BORDER_EN is undefined apply zero padding per REQ-021.

Verification (IMG_W=IMG_H=4, mem[a]=a)
REQ-033 SHALL cover: start at centre (0,0), macro off -> win_data p0..p8 = 0,0,0,0,0,1,0,4,5; win_addr=0; win_valid rises in cycle 11.
REQ-034 SHALL cover: same window with REPLICATE_BORDER_EN -> p0..p8 = 0,0,1,0,0,1,4,4,5.
REQ-035 SHALL cover: window at centre (1,1) -> p0..p8 = 0,1,2,4,5,6,8,9,10; win_addr=5; 9 bram_ena cycles.
REQ-036 SHALL cover: win_ready held 0 for 5 cycles in EMIT -> win_data and win_addr unchanged, bram_ena=0, no advance.
REQ-037 SHALL cover: full frame with win_ready=1 -> 16 windows, win_addr 0..15 in order, one done pulse, busy falls after it, start pulsed while busy ignored.
REQ-038 SHALL cover: rst_n=0 during the 3rd window's FETCH -> next cycle IDLE, all outputs 0, no done; the next start restarts at win_addr=0.

Source files
------------

// File: rtl/bram_window_fetch.sv
// Raster-scans an IMG_W x IMG_H image held in a single-port BRAM and emits one 3x3
// neighbourhood per pixel. Define REPLICATE_BORDER_EN for edge replication instead of zero padding.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 18
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module bram_window_fetch #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic                      clka,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      bram_ena,
    output logic                      bram_wea,
    output logic [`ADDR_WIDTH-1:0]    bram_addra,
    input  logic [`BIT_WIDTH-1:0]     bram_douta,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [9*`BIT_WIDTH-1:0]   win_data,
    output logic [`ADDR_WIDTH-1:0]    win_addr
);

    localparam int AW    = `ADDR_WIDTH;
    localparam int BW    = `BIT_WIDTH;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_k;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [BW-1:0]     r_slot [9];
    logic              r_cap_en;
    logic              r_cap_zero;
    logic [3:0]        r_cap_slot;

    logic [1:0]        w_dr;
    logic [1:0]        w_dc;
    logic [10:0]       w_nb_row;
    logic [10:0]       w_nb_col;
    logic [10:0]       w_rd_row;
    logic [10:0]       w_rd_col;
    logic              w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic              w_last;
    logic              w_accept;

    // Neighbour offset for fetch step k: row offset k/3, column offset k%3 (both biased by +1).
    always_comb begin
        w_dr = 2'd0;
        w_dc = 2'd0;
        case (r_k)
            4'd0, 4'd1, 4'd2: w_dr = 2'd0;
            4'd3, 4'd4, 4'd5: w_dr = 2'd1;
            default:          w_dr = 2'd2;
        endcase
        case (r_k)
            4'd0, 4'd3, 4'd6: w_dc = 2'd0;
            4'd1, 4'd4, 4'd7: w_dc = 2'd1;
            default:          w_dc = 2'd2;
        endcase
    end

    // A coordinate of -1 wraps to 2047, so one unsigned compare covers both image edges.
    assign w_nb_row = 11'(r_row) + 11'(w_dr) - 11'd1;
    assign w_nb_col = 11'(r_col) + 11'(w_dc) - 11'd1;

`ifdef REPLICATE_BORDER_EN
    always_comb begin
        w_rd_row = w_nb_row;
        w_rd_col = w_nb_col;
        if (w_nb_row[10])                   w_rd_row = 11'd0;
        else if (w_nb_row >= 11'(IMG_H))    w_rd_row = 11'(IMG_H - 1);
        if (w_nb_col[10])                   w_rd_col = 11'd0;
        else if (w_nb_col >= 11'(IMG_W))    w_rd_col = 11'(IMG_W - 1);
    end
    assign w_rd_en = 1'b1;
`else
    assign w_rd_row = w_nb_row;
    assign w_rd_col = w_nb_col;
    assign w_rd_en  = (w_nb_row < 11'(IMG_H)) && (w_nb_col < 11'(IMG_W));
`endif

    assign w_rd_addr = (AW'(w_rd_row) << COL_W) | AW'(w_rd_col);
    assign win_addr  = (AW'(r_row) << COL_W) | AW'(r_col);
    assign w_last    = (r_row == ROW_W'(IMG_H - 1)) && (r_col == COL_W'(IMG_W - 1));
    assign w_accept  = (r_state == S_EMIT) && win_ready;
    assign bram_wea  = 1'b0;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_data[i*BW +: BW] = r_slot[i];
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        win_valid   = 1'b0;
        bram_ena    = 1'b0;
        bram_addra  = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                busy       = 1'b1;
                bram_ena   = w_rd_en;
                bram_addra = w_rd_en ? w_rd_addr : '0;
                if (r_k == 4'd8) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy        = 1'b1;
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                if (win_ready) w_state_nxt = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_k        <= 4'd0;
            r_row      <= '0;
            r_col      <= '0;
            r_cap_en   <= 1'b0;
            r_cap_zero <= 1'b0;
            r_cap_slot <= 4'd0;
            // NOTE: the window slots are plain flops, not RAM, so clearing them on reset is cheap.
            for (int i = 0; i < 9; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_k     <= (r_state == S_FETCH && r_k != 4'd8) ? r_k + 4'd1 : 4'd0;

            // Read data lags the address by one cycle, so the slot write is deferred by one cycle.
            r_cap_en   <= (r_state == S_FETCH);
            r_cap_slot <= r_k;
            r_cap_zero <= !w_rd_en;
            for (int i = 0; i < 9; i++) begin
                if (r_cap_en && r_cap_slot == 4'(i)) begin
                    r_slot[i] <= r_cap_zero ? '0 : bram_douta;
                end
            end

            if (r_state == S_IDLE && start) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (r_col == COL_W'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_window_fetch.sv
// Directed bench for bram_window_fetch on a 4x4 image with mem[a] = a.
// Expected windows switch with REPLICATE_BORDER_EN.

module tb_bram_window_fetch;

    localparam int W = 4;
    localparam int H = 4;

`ifdef REPLICATE_BORDER_EN
    localparam logic [71:0] EXP_W0   = {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    localparam int          ENA_W0   = 9;
    localparam logic        EXP_E1   = 1'b1;
    localparam logic [17:0] EXP_A3   = 18'd1;
`else
    localparam logic [71:0] EXP_W0   = {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam int          ENA_W0   = 4;
    localparam logic        EXP_E1   = 1'b0;
    localparam logic [17:0] EXP_A3   = 18'd0;
`endif
    localparam logic [71:0] EXP_W5   = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        win_ready = 1'b0;
    logic [7:0]  bram_douta = 8'd0;
    logic        busy, done, bram_ena, bram_wea, win_valid;
    logic [17:0] bram_addra, win_addr;
    logic [71:0] win_data;

    int n_vec = 0;
    int n_err = 0;

    bram_window_fetch #(.IMG_W(W), .IMG_H(H)) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_douta (bram_douta),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_addr   (win_addr)
    );

    always #5 clka = ~clka;

    // BRAM model: registered read, contents equal to the address.
    always @(posedge clka) begin
        if (bram_ena) bram_douta <= (bram_addra < 18'd16) ? bram_addra[7:0] : 8'hEE;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept the window on show, then count cycles (and enabled reads) until the next one appears.
    task automatic accept_and_wait(output int cyc, output int enas);
        win_ready = 1'b1;
        @(negedge clka);
        win_ready = 1'b0;
        cyc  = 1;
        enas = int'(bram_ena);
        while (!win_valid && cyc < 40) begin
            @(negedge clka);
            cyc++;
            enas += int'(bram_ena);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy,       1'b0);
        check({tag, "_done"},  done,       1'b0);
        check({tag, "_valid"}, win_valid,  1'b0);
        check({tag, "_ena"},   bram_ena,   1'b0);
        check({tag, "_addra"}, bram_addra, 18'd0);
        check({tag, "_waddr"}, win_addr,   18'd0);
        check({tag, "_wdata"}, win_data,   72'd0);
    endtask

    logic        ena_q  [1:11];
    logic [17:0] addr_q [1:11];
    logic        vld_q  [1:11];
    logic        busy10;

    initial begin
        int cyc, enas, exp_addr, dones, hs, ena_sum, vld_sum, stray;

        // Reset state
        repeat (3) @(negedge clka);
        check_all_zero("rst");
        check("rst_wea", bram_wea, 1'b0);
        rst_n = 1'b1;
        @(negedge clka);
        check("idle_busy", busy, 1'b0);

        // First window at (0,0): start sampled at edge 0, cycles 1..11 follow
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            if (n > 1) @(negedge clka);
            ena_q[n]  = bram_ena;
            addr_q[n] = bram_addra;
            vld_q[n]  = win_valid;
            if (n == 10) busy10 = busy;
        end
        ena_sum = 0;
        vld_sum = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n <= 9) ena_sum += int'(ena_q[n]);
            vld_sum += int'(vld_q[n]);
        end
        check("w0_ena_count", ena_sum, ENA_W0);
        check("w0_ena_c1",    ena_q[1], EXP_E1);
        check("w0_addr_c3",   addr_q[3], EXP_A3);
        check("w0_ena_c5",    ena_q[5], 1'b1);
        check("w0_addr_c5",   addr_q[5], 18'd0);
        check("w0_addr_c9",   addr_q[9], 18'd5);
        check("w0_wait_ena",  ena_q[10], 1'b0);
        check("w0_wait_busy", busy10, 1'b1);
        check("w0_early_vld", vld_sum, 0);
        check("w0_valid_c11", vld_q[11], 1'b1);
        check("w0_data",      win_data, EXP_W0);
        check("w0_addr",      win_addr, 18'd0);

        // Stall: win_ready low for 5 EMIT cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clka);
            check("stall_valid", win_valid, 1'b1);
            check("stall_data",  win_data,  EXP_W0);
            check("stall_addr",  win_addr,  18'd0);
            check("stall_ena",   bram_ena,  1'b0);
        end

        // Windows 1..5: 11-cycle spacing, window (1,1) fully read from BRAM
        accept_and_wait(cyc, enas);
        check("w1_latency", cyc, 11);
        check("w1_addr", win_addr, 18'd1);
        for (int w = 2; w <= 5; w++) begin
            accept_and_wait(cyc, enas);
            check("wn_addr", win_addr, 18'(w));
        end
        check("w5_latency", cyc, 11);
        check("w5_ena_count", enas, 9);
        check("w5_data", win_data, EXP_W5);

        // Stream the rest of the frame with win_ready held high; poke start mid-frame
        win_ready = 1'b1;
        exp_addr  = 5;
        dones     = 0;
        cyc       = 0;
        while (cyc < 400 && dones == 0) begin
            if (win_valid) begin
                check("frame_addr", win_addr, 18'(exp_addr));
                exp_addr++;
            end
            start = (cyc == 20);
            @(negedge clka);
            cyc++;
            if (done) dones++;
        end
        start     = 1'b0;
        win_ready = 1'b0;
        check("frame_windows", exp_addr, 16);
        check("frame_done_seen", dones, 1);
        check("frame_busy_at_done", busy, 1'b1);
        @(negedge clka);
        check("frame_done_width", done, 1'b0);
        check("frame_busy_after", busy, 1'b0);
        stray = 0;
        repeat (4) begin
            @(negedge clka);
            stray += int'(busy) + int'(done);
        end
        check("frame_no_restart", stray, 0);

        // Reset during the third window's FETCH
        start = 1'b1;
        @(negedge clka);
        start     = 1'b0;
        win_ready = 1'b1;
        hs  = 0;
        cyc = 0;
        while (hs < 2 && cyc < 100) begin
            if (win_valid) hs++;
            @(negedge clka);
            cyc++;
        end
        check("rstmid_two_windows", hs, 2);
        repeat (2) @(negedge clka);
        check("rstmid_in_fetch", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clka);
        check_all_zero("rstmid");
        rst_n     = 1'b1;
        win_ready = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge clka);
            stray += int'(busy) + int'(done);
        end
        check("rstmid_needs_start", stray, 0);

        // Restart after reset begins again at pixel 0
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        cyc = 1;
        while (!win_valid && cyc < 40) begin
            @(negedge clka);
            cyc++;
        end
        check("restart_latency", cyc, 11);
        check("restart_addr", win_addr, 18'd0);
        check("restart_data", win_data, EXP_W0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
